// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared state encoding and bus constants for the CPU memory bus
//
// Contents:
//   gb_state_t  : machine-cycle states ST_IDLE, ST_T1..ST_T4
//   GB_OPEN_BUS : value seen on an undriven data bus (also used by the MMU)
package gb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } gb_state_t;

  localparam logic [7:0] GB_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/gb_bus_ctrl.sv
// rtl/gb_bus_ctrl.sv - memory-side responder running one request as a T1..T4 machine cycle
//
// Ports:
//   clk, rst                 : clock (one T-state per cycle), async active-low reset
//   req, we, addr, wdata     : request side, sampled when ready=1
//   ready                    : combinational, high in IDLE and T4
//   rdata, rdata_valid       : read data and one-cycle update pulse
//   bus_err                  : one-cycle pulse in T4 of a timed-out transaction
//   mem_addr, mem_dout       : registered external address / write data
//   mem_oe                   : external data driver enable (writes only)
//   mem_din, mem_ready       : external read data and wait-state input
//   mem_cs_n/rd_n/wr_n       : active-low chip select and strobes
module gb_bus_ctrl
  import gb_bus_pkg::*;
#(
  parameter int             TIMEOUT  = 255,
  parameter logic [7:0]     OPEN_BUS = GB_OPEN_BUS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_oe,
  input  logic [7:0]  mem_din,
  output logic        mem_cs_n,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic        mem_ready
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  gb_state_t  state;
  logic       we_q;
  logic [7:0] wait_cnt;

  assign ready = (state == ST_IDLE) || (state == ST_T4);

  // Every output is registered: the values a state shows are loaded on the
  // edge that enters it, so each branch below sets up the *next* state's pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      wait_cnt    <= 8'd0;
      rdata       <= 8'd0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      mem_addr    <= 16'd0;
      mem_dout    <= 8'd0;
      mem_oe      <= 1'b0;
      mem_cs_n    <= 1'b1;
      mem_rd_n    <= 1'b1;
      mem_wr_n    <= 1'b1;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        ST_IDLE, ST_T4: begin
          mem_rd_n <= 1'b1;
          mem_wr_n <= 1'b1;
          if (req) begin
            // Accepting from T4 keeps cs_n low across back-to-back cycles.
            state    <= ST_T1;
            we_q     <= we;
            mem_addr <= addr;
            mem_dout <= wdata;
            mem_oe   <= we;
            mem_cs_n <= 1'b0;
            wait_cnt <= 8'd0;
          end else begin
            state    <= ST_IDLE;
            mem_oe   <= 1'b0;
            mem_cs_n <= 1'b1;
          end
        end
        ST_T1: begin
          state    <= ST_T2;
          mem_rd_n <= we_q;
          mem_wr_n <= ~we_q;
        end
        ST_T2: begin
          state <= ST_T3;
        end
        ST_T3: begin
          // A ready memory wins over an expiring counter on the same edge.
          if (mem_ready || (wait_cnt == TIMEOUT_CNT)) begin
            state    <= ST_T4;
            mem_rd_n <= 1'b1;
            mem_wr_n <= 1'b1;
            bus_err  <= ~mem_ready;
            if (!we_q) begin
              rdata       <= mem_ready ? mem_din : OPEN_BUS;
              rdata_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_oe   <= 1'b0;
          mem_cs_n <= 1'b1;
          mem_rd_n <= 1'b1;
          mem_wr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_bus_ctrl.sv
// tb/tb_gb_bus_ctrl.sv - directed self-checking bench for gb_bus_ctrl
module tb_gb_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_oe;
  logic [7:0]  mem_din;
  logic        mem_cs_n;
  logic        mem_rd_n;
  logic        mem_wr_n;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  gb_bus_ctrl #(.TIMEOUT(4), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_oe(mem_oe), .mem_din(mem_din),
    .mem_cs_n(mem_cs_n), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
    .mem_ready(mem_ready)
  );

  // Memory model: data is the low address byte xor 5A (C000 -> 5A, 12FD -> A7).
  assign mem_din = mem_addr[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 8'h0; mem_ready = 1'b1;
    #1 rst = 1'b0;
    #7;
    chk("rst_ready", ready, 1);
    chk("rst_cs_n", mem_cs_n, 1);
    chk("rst_rd_n", mem_rd_n, 1);
    chk("rst_wr_n", mem_wr_n, 1);
    chk("rst_oe", mem_oe, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_err", bus_err, 0);
    #2 rst = 1'b1;
    tick();
    chk("idle_hold_cs_n", mem_cs_n, 1);
    chk("idle_hold_ready", ready, 1);

    // Zero-wait read of C000
    req = 1'b1; we = 1'b0; addr = 16'hC000;
    tick();
    req = 1'b0;
    chk("rd_t1_cs_n", mem_cs_n, 0);
    chk("rd_t1_rd_n", mem_rd_n, 1);
    chk("rd_t1_addr", mem_addr, 16'hC000);
    chk("rd_t1_oe", mem_oe, 0);
    chk("rd_t1_ready", ready, 0);
    tick();
    chk("rd_t2_rd_n", mem_rd_n, 0);
    chk("rd_t2_wr_n", mem_wr_n, 1);
    tick();
    chk("rd_t3_rd_n", mem_rd_n, 0);
    chk("rd_t3_wr_n", mem_wr_n, 1);
    chk("rd_t3_valid", rdata_valid, 0);
    tick();
    chk("rd_t4_rd_n", mem_rd_n, 1);
    chk("rd_t4_cs_n", mem_cs_n, 0);
    chk("rd_t4_valid", rdata_valid, 1);
    chk("rd_t4_rdata", rdata, 8'h5A);
    chk("rd_t4_err", bus_err, 0);
    chk("rd_t4_ready", ready, 1);
    tick();
    chk("rd_idle_cs_n", mem_cs_n, 1);
    chk("rd_idle_valid", rdata_valid, 0);
    chk("rd_idle_rdata", rdata, 8'h5A);

    // Write 3C to FF80
    req = 1'b1; we = 1'b1; addr = 16'hFF80; wdata = 8'h3C;
    tick();
    req = 1'b0; we = 1'b0;
    chk("wr_t1_oe", mem_oe, 1);
    chk("wr_t1_dout", mem_dout, 8'h3C);
    chk("wr_t1_addr", mem_addr, 16'hFF80);
    chk("wr_t1_wr_n", mem_wr_n, 1);
    chk("wr_t1_cs_n", mem_cs_n, 0);
    tick();
    chk("wr_t2_wr_n", mem_wr_n, 0);
    chk("wr_t2_rd_n", mem_rd_n, 1);
    chk("wr_t2_oe", mem_oe, 1);
    tick();
    chk("wr_t3_wr_n", mem_wr_n, 0);
    chk("wr_t3_oe", mem_oe, 1);
    tick();
    chk("wr_t4_wr_n", mem_wr_n, 1);
    chk("wr_t4_oe", mem_oe, 1);
    chk("wr_t4_valid", rdata_valid, 0);
    chk("wr_t4_rdata", rdata, 8'h5A);
    tick();
    chk("wr_idle_oe", mem_oe, 0);
    chk("wr_idle_cs_n", mem_cs_n, 1);

    // Read 12FD with three wait states: valid at k+7
    req = 1'b1; we = 1'b0; addr = 16'h12FD; mem_ready = 1'b0;
    tick();
    req = 1'b0;
    tick();
    for (int c = 3; c <= 6; c++) begin
      tick();
      if (c == 6) mem_ready = 1'b1;
      chk($sformatf("ws_t3_rd_n_%0d", c), mem_rd_n, 0);
      chk($sformatf("ws_t3_valid_%0d", c), rdata_valid, 0);
    end
    tick();
    chk("ws_t4_valid", rdata_valid, 1);
    chk("ws_t4_rdata", rdata, 8'hA7);
    chk("ws_t4_rd_n", mem_rd_n, 1);
    tick();

    // Timeout with TIMEOUT=4: T4 at k+8
    req = 1'b1; we = 1'b0; addr = 16'h4000; mem_ready = 1'b0;
    tick();
    req = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk($sformatf("to_err_%0d", c), bus_err, 0);
      chk($sformatf("to_valid_%0d", c), rdata_valid, 0);
    end
    tick();
    chk("to_t4_err", bus_err, 1);
    chk("to_t4_valid", rdata_valid, 1);
    chk("to_t4_rdata", rdata, 8'hFF);
    chk("to_t4_rd_n", mem_rd_n, 1);
    mem_ready = 1'b1;
    tick();
    chk("to_idle_err", bus_err, 0);
    chk("to_idle_cs_n", mem_cs_n, 1);
    chk("to_idle_ready", ready, 1);

    // Four back-to-back reads, req held high
    req = 1'b1; we = 1'b0; addr = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_t1_addr_%0d", i), mem_addr, 16'h2000 + 16'(i));
      chk($sformatf("b2b_t1_cs_%0d", i), mem_cs_n, 0);
      chk($sformatf("b2b_t1_valid_%0d", i), rdata_valid, 0);
      if (i < 3) addr = 16'h2000 + 16'(i + 1);
      else req = 1'b0;
      tick();
      chk($sformatf("b2b_t2_cs_%0d", i), mem_cs_n, 0);
      chk($sformatf("b2b_t2_valid_%0d", i), rdata_valid, 0);
      tick();
      chk($sformatf("b2b_t3_cs_%0d", i), mem_cs_n, 0);
      chk($sformatf("b2b_t3_valid_%0d", i), rdata_valid, 0);
      tick();
      chk($sformatf("b2b_t4_cs_%0d", i), mem_cs_n, 0);
      chk($sformatf("b2b_t4_valid_%0d", i), rdata_valid, 1);
      chk($sformatf("b2b_t4_rdata_%0d", i), rdata, 8'(i) ^ 8'h5A);
    end
    tick();
    chk("b2b_idle_cs_n", mem_cs_n, 1);

    // Reset asserted during T2 of a write
    req = 1'b1; we = 1'b1; addr = 16'h8001; wdata = 8'h99;
    tick();
    req = 1'b0; we = 1'b0;
    tick();
    chk("rw_t2_wr_n", mem_wr_n, 0);
    #2 rst = 1'b0;
    #1;
    chk("rw_async_wr_n", mem_wr_n, 1);
    chk("rw_async_cs_n", mem_cs_n, 1);
    chk("rw_async_oe", mem_oe, 0);
    chk("rw_async_valid", rdata_valid, 0);
    chk("rw_async_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rw_rel_ready", ready, 1);
    chk("rw_rel_cs_n", mem_cs_n, 1);
    chk("rw_rel_valid", rdata_valid, 0);
    chk("rw_rel_err", bus_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_bus_ctrl.md
# gb_bus_ctrl

Memory-side responder for the CPU address/data bus: accepts one read or write request from the register file/datapath side and runs it as a 4-T-state machine cycle (T1–T4) on the external memory interface. Drives chip-select and read/write strobes, latches the address, and returns read data with a one-cycle valid pulse. Wait states are supported through `mem_ready`, and a timeout returns open-bus data.

## Interface
Parameters:
- `TIMEOUT`, 255, max wait-state cycles in T3 before abort (1..255)
- `OPEN_BUS`, 8'hFF, read data returned on timeout

Ports:
- `clk`  in  1  system clock (one T-state per cycle)
- `rst`  in  1  reset, asynchronous, active-low
- `req`  in  1  transaction request, sampled when `ready`=1
- `we`  in  1  1 = write, 0 = read; sampled with `req`
- `addr`  in  16  transaction address; sampled with `req`
- `wdata`  in  8  write data; sampled with `req`
- `ready`  out  1  can accept request this cycle
- `rdata`  out  8  read data, held until next read completes
- `rdata_valid`  out  1  one-cycle pulse: `rdata` updated
- `bus_err`  out  1  one-cycle pulse: transaction timed out
- `mem_addr`  out  16  external address, registered
- `mem_dout`  out  8  external write data, registered
- `mem_oe`  out  1  enable for the external data driver
- `mem_din`  in  8  external read data
- `mem_cs_n`  out  1  chip select, active-low
- `mem_rd_n`  out  1  read strobe, active-low
- `mem_wr_n`  out  1  write strobe, active-low
- `mem_ready`  in  1  memory ready; low inserts wait states in T3

## Operation
- States: IDLE, T1, T2, T3, T4.
- Accept: `req & ready` at a posedge. That edge latches `addr`/`wdata`/`we` and moves the FSM to T1.
- `ready` = (state==IDLE) | (state==T4). This is combinational from state.
- IDLE: all strobes are deasserted. Without `req` the FSM stays in IDLE.
- T1: `mem_cs_n`=0 and `mem_addr` is valid. On a write, `mem_oe`=1 and `mem_dout` = latched wdata. Next state is T2.
- T2: `mem_rd_n`=0 (read) or `mem_wr_n`=0 (write). Next state is T3.
- T3: strobes stay asserted.
  - If `mem_ready`=1, go to T4. On a read, this same edge captures `mem_din` into `rdata`.
  - If `mem_ready`=0, stay in T3 and increment the wait counter.
  - If the wait counter reaches TIMEOUT, go to T4. `rdata` gets OPEN_BUS on a read, and `bus_err` pulses in T4.
- T4: `mem_rd_n`/`mem_wr_n` are deasserted and `mem_cs_n` stays 0. `rdata_valid`=1 for a read, including a timeout read.
  - Next state is T1 if a new request is accepted, otherwise IDLE.
  - On back-to-back transactions, `mem_cs_n` stays low continuously.
- Write data is never returned; `rdata` is unchanged by writes.
- The wait counter is 8 bits and clears on entry to T1.
- `mem_addr`, `mem_dout`, `rdata` hold their last value in IDLE. `mem_oe` drops in IDLE and in T1 of a read.
- `req` outside `ready` is ignored. There is no queueing.

## Timing
- All outputs are registered except `ready`.
- Reset values:
  - state IDLE, `ready`=1
  - `mem_cs_n`=`mem_rd_n`=`mem_wr_n`=1
  - `mem_oe`=0, `mem_addr`=0, `mem_dout`=0
  - `rdata`=0, `rdata_valid`=0, `bus_err`=0, wait counter 0
- Zero-wait read: accept at edge k. T1 in cycle k+1, T2 in k+2, T3 in k+3. `mem_din` is sampled at edge k+4. `rdata_valid`=1 in cycle k+4 (T4).
- Latency is 4 cycles accept-to-valid, plus N for N wait cycles.
- Throughput: one transaction per 4 cycles with back-to-back accepts in T4.
- Timeout: `bus_err` and `rdata_valid` are high in the same T4 cycle, TIMEOUT+4 cycles after accept.
- Reset mid-transaction: asynchronous. Strobes deassert and `mem_oe` drops immediately with no T4. No `rdata_valid` and no `bus_err`.

## Structure
- Shared package `gb_bus_pkg`:
  - state encoding localparams ST_IDLE, ST_T1..ST_T4
  - `GB_OPEN_BUS` = 8'hFF, also used by the MMU
- No sub-module. FSM, 8-bit wait counter and output registers are in one module.

## Test plan
- Read 16'hC000, memory model returns 8'h5A, `mem_ready`=1 → `rd_n` low exactly in cycles k+2..k+3; `rdata`=8'h5A and `rdata_valid` pulse in cycle k+4; `we`-side strobes never low.
- Write 16'hFF80 data 8'h3C → `mem_wr_n` low cycles k+2..k+3, `mem_oe`=1 in T1–T4, `mem_dout`=8'h3C; `rdata` unchanged and no `rdata_valid`.
- Read with `mem_ready` held low 3 cycles in T3 → `rdata_valid` at cycle k+7 with correct data; strobe stays low throughout.
- `mem_ready` stuck low, TIMEOUT=4 → `bus_err` and `rdata_valid` in the same cycle, `rdata`=8'hFF, FSM returns to IDLE.
- Four back-to-back reads with `req` held high → accepts every 4th edge, `mem_cs_n` continuously low, four `rdata_valid` pulses 4 cycles apart.
- Assert `rst` low during T2 of a write → `mem_wr_n`=1, `mem_cs_n`=1, `mem_oe`=0 before the next clock edge; after release, `ready`=1 and IDLE.
